// File: rtl/rs232_status_tx.sv
// Serializes ACK / STATUS reply packets to the PC as 8N1 frames, bytes back-to-back, one DIV-cycle bit period.
// Latency: start bit on the line the cycle after a request is sampled; oDONE one cycle after the final stop bit.
// Backpressure: none upstream; one request queues behind the packet on the line, further ones pulse oOVERRUN.
module rs232_status_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int BIT_NUM  = 32
) (
    input  logic               iCLK,
    input  logic               iNRST,
    input  logic               iREQ_ACK,
    input  logic [7:0]         iACK_CODE,
    input  logic               iREQ_STATUS,
    input  logic               iARMED,
    input  logic               iRUNNING,
    input  logic [BIT_NUM-1:0] iTIME,
    output logic               oTXD,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oOVERRUN
);
    localparam int DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int NT     = BIT_NUM / 8;
    localparam int MAXLEN = NT + 3;
    localparam int PW     = MAXLEN * 8;
    localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW     = $clog2(MAXLEN + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [DW-1:0]      divCnt;
    logic [3:0]         bitCnt;
    logic [LW-1:0]      bytesLeft;
    logic [PW-1:0]      pktBuf;
    logic [7:0]         curByte;

    logic               pendVld;
    logic               pendIsStat;
    logic [7:0]         pendCode;
    logic [1:0]         pendFlags;
    logic [BIT_NUM-1:0] pendTime;

    logic               launchPend;
    logic               launchNew;
    logic               launch;
    logic               storeReq;
    logic               storeIsStat;
    logic               dropReq;
    logic               ldIsStat;
    logic [7:0]         ldCode;
    logic [1:0]         ldFlags;
    logic [BIT_NUM-1:0] ldTime;
    logic [PW-1:0]      ldBuf;
    logic [LW-1:0]      ldLen;
    logic [7:0]         chk;
    logic [BIT_NUM-1:0] tmpTime;
    logic               bitEnd;
    logic               lastBit;
    logic               lastByte;

    assign curByte  = pktBuf[PW-1 -: 8];
    assign bitEnd   = (divCnt == DW'(DIV - 1));
    assign lastBit  = (bitCnt == 4'd9);
    assign lastByte = (bytesLeft == LW'(1));

    // A waiting request always launches before a new one; the slot it vacates can be refilled in the same cycle.
    always_comb begin
        launchPend  = (state == IDLE) && pendVld;
        launchNew   = (state == IDLE) && !pendVld && (iREQ_ACK || iREQ_STATUS);
        launch      = launchPend || launchNew;
        storeReq    = 1'b0;
        storeIsStat = 1'b0;
        dropReq     = 1'b0;
        if (launchNew) begin
            storeReq    = iREQ_ACK && iREQ_STATUS;
            storeIsStat = 1'b1;
        end else if (iREQ_ACK || iREQ_STATUS) begin
            storeReq    = !pendVld || launchPend;
            storeIsStat = !iREQ_ACK;
            dropReq     = (iREQ_ACK && iREQ_STATUS) || !storeReq;
        end
    end

    always_comb begin
        ldIsStat = launchPend ? pendIsStat : !iREQ_ACK;
        ldCode   = launchPend ? pendCode   : iACK_CODE;
        ldFlags  = launchPend ? pendFlags  : {iRUNNING, iARMED};
        ldTime   = launchPend ? pendTime   : iTIME;
        chk      = 8'h5A ^ {6'b0, ldFlags};
        tmpTime  = ldTime;
        for (int i = 0; i < NT; i++) begin
            chk     = chk ^ tmpTime[7:0];
            tmpTime = tmpTime >> 8;
        end
        // Packet is held MSB-first so the byte on the line is always the top byte.
        if (ldIsStat) begin
            ldBuf = {8'h5A, 6'b0, ldFlags, ldTime, chk};
            ldLen = LW'(NT + 3);
        end else begin
            ldBuf = {8'hA5, ldCode, 8'hA5 ^ ldCode, {(NT * 8){1'b0}}};
            ldLen = LW'(3);
        end
    end

    always_ff @(posedge iCLK or negedge iNRST) begin
        if (!iNRST) begin
            state      <= IDLE;
            divCnt     <= '0;
            bitCnt     <= '0;
            bytesLeft  <= '0;
            pktBuf     <= '0;
            pendVld    <= 1'b0;
            pendIsStat <= 1'b0;
            pendCode   <= '0;
            pendFlags  <= '0;
            pendTime   <= '0;
            oTXD       <= 1'b1;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oOVERRUN   <= 1'b0;
        end else begin
            oDONE    <= 1'b0;
            oOVERRUN <= dropReq;
            if (storeReq) begin
                pendVld    <= 1'b1;
                pendIsStat <= storeIsStat;
                pendCode   <= iACK_CODE;
                pendFlags  <= {iRUNNING, iARMED};
                pendTime   <= iTIME;
            end else if (launchPend) begin
                pendVld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= SEND;
                        pktBuf    <= ldBuf;
                        bytesLeft <= ldLen;
                        bitCnt    <= '0;
                        divCnt    <= '0;
                        oTXD      <= 1'b0;
                        oBUSY     <= 1'b1;
                    end else begin
                        oTXD  <= 1'b1;
                        oBUSY <= 1'b0;
                    end
                end
                SEND: begin
                    if (!bitEnd) begin
                        divCnt <= divCnt + 1'b1;
                    end else begin
                        divCnt <= '0;
                        if (!lastBit) begin
                            bitCnt <= bitCnt + 1'b1;
                            oTXD   <= (bitCnt == 4'd8) ? 1'b1 : curByte[bitCnt[2:0]];
                        end else if (!lastByte) begin
                            bitCnt    <= '0;
                            bytesLeft <= bytesLeft - 1'b1;
                            pktBuf    <= pktBuf << 8;
                            oTXD      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            oTXD  <= 1'b1;
                            oDONE <= 1'b1;
                            oBUSY <= pendVld || storeReq;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_status_tx.sv
// Bench for rs232_status_tx: a line decoder rebuilds frames from oTXD and a packet-level model predicts bytes and bit timing.
module tb_rs232_status_tx;
    localparam int DA = (1000 + 100 / 2) / 100;
    localparam int DB = (67200 + 9600 / 2) / 9600;

    typedef struct {
        logic [7:0] dat;
        int         st;
        bit         ok;
    } rx_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;

    logic        aReqAck = 1'b0, aReqSt = 1'b0, aArmed = 1'b0, aRun = 1'b0;
    logic [7:0]  aCode = '0;
    logic [31:0] aTime = '0;
    logic        aTxd, aBusy, aDone, aOv;
    logic        bReqAck = 1'b0, bReqSt = 1'b0, bArmed = 1'b0, bRun = 1'b0;
    logic [7:0]  bCode = '0;
    logic [15:0] bTime = '0;
    logic        bTxd, bBusy, bDone, bOv;

    rx_t rxQ[2][$];
    rx_t expQ[2][$];
    int  doneQ[2][$];
    bit  doneBusyQ[2][$];
    int  ovQ[2][$];
    int  nChecks = 0;
    int  nFails = 0;

    rs232_status_tx #(.CLK_FREQ(1000), .BAUD(100), .BIT_NUM(32)) dut (
        .iCLK(clk), .iNRST(nrst), .iREQ_ACK(aReqAck), .iACK_CODE(aCode), .iREQ_STATUS(aReqSt),
        .iARMED(aArmed), .iRUNNING(aRun), .iTIME(aTime),
        .oTXD(aTxd), .oBUSY(aBusy), .oDONE(aDone), .oOVERRUN(aOv)
    );

    rs232_status_tx #(.CLK_FREQ(67200), .BAUD(9600), .BIT_NUM(16)) dut16 (
        .iCLK(clk), .iNRST(nrst), .iREQ_ACK(bReqAck), .iACK_CODE(bCode), .iREQ_STATUS(bReqSt),
        .iARMED(bArmed), .iRUNNING(bRun), .iTIME(bTime),
        .oTXD(bTxd), .oBUSY(bBusy), .oDONE(bDone), .oOVERRUN(bOv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (aDone === 1'b1) begin doneQ[0].push_back(cyc); doneBusyQ[0].push_back(aBusy); end
        if (bDone === 1'b1) begin doneQ[1].push_back(cyc); doneBusyQ[1].push_back(bBusy); end
        if (aOv === 1'b1) ovQ[0].push_back(cyc);
        if (bOv === 1'b1) ovQ[1].push_back(cyc);
    end

    function automatic logic txdOf(input int idx);
        return (idx == 0) ? aTxd : bTxd;
    endfunction

    // Decodes 8N1 frames; every cycle of a bit must hold the same level, the stop bit must be 1.
    task automatic monitor(input int idx, input int div);
        rx_t  r;
        logic v;
        bit   abort;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && txdOf(idx) === 1'b0) begin
                r.st = cyc; r.ok = 1'b1; r.dat = '0; abort = 1'b0; v = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int j = 0; j < div; j++) begin
                        if (b != 0 || j != 0) @(negedge clk);
                        if (nrst !== 1'b1) abort = 1'b1;
                        if (j == 0) v = txdOf(idx);
                        else if (txdOf(idx) !== v) r.ok = 1'b0;
                    end
                    if (b >= 1 && b <= 8) r.dat[b-1] = v;
                    if (b == 9 && v !== 1'b1) r.ok = 1'b0;
                end
                if (!abort) rxQ[idx].push_back(r);
            end
        end
    endtask

    initial monitor(0, DA);
    initial monitor(1, DB);

    task automatic expAck(input int idx, input logic [7:0] code, input int st, input int div);
        logic [7:0] b[$];
        rx_t r;
        b.push_back(8'hA5);
        b.push_back(code);
        b.push_back(8'hA5 ^ code);
        foreach (b[i]) begin r.dat = b[i]; r.st = st + i * 10 * div; r.ok = 1'b1; expQ[idx].push_back(r); end
    endtask

    task automatic expStatus(input int idx, input bit armed, input bit running, input logic [31:0] t,
                             input int nt, input int st, input int div);
        logic [7:0] b[$];
        logic [7:0] chk;
        rx_t r;
        b.push_back(8'h5A);
        b.push_back({6'b0, running, armed});
        for (int i = 0; i < nt; i++) b.push_back(8'((t >> (8 * (nt - 1 - i))) & 32'hFF));
        chk = 8'h00;
        foreach (b[i]) chk = chk ^ b[i];
        b.push_back(chk);
        foreach (b[i]) begin r.dat = b[i]; r.st = st + i * 10 * div; r.ok = 1'b1; expQ[idx].push_back(r); end
    endtask

    // Counts byte-level differences between decoded and predicted streams, then empties both.
    task automatic drain(input int idx, output int nErr);
        rx_t r, e;
        nErr = 0;
        if (rxQ[idx].size() != expQ[idx].size()) begin
            $display("  line%0d: %0d bytes decoded, %0d predicted", idx, rxQ[idx].size(), expQ[idx].size());
            nErr++;
        end
        while (rxQ[idx].size() > 0 && expQ[idx].size() > 0) begin
            r = rxQ[idx].pop_front();
            e = expQ[idx].pop_front();
            if (r.dat !== e.dat || r.st !== e.st || !r.ok) begin
                $display("  line%0d: got %02h @%0d framing_ok=%0d, want %02h @%0d", idx, r.dat, r.st, r.ok, e.dat, e.st);
                nErr++;
            end
        end
        rxQ[idx].delete(); expQ[idx].delete();
        doneQ[idx].delete(); doneBusyQ[idx].delete(); ovQ[idx].delete();
    endtask

    task automatic pulse(input int idx, input bit a, input bit s, output int acc);
        @(negedge clk);
        if (idx == 0) begin aReqAck = a; aReqSt = s; end
        else begin bReqAck = a; bReqSt = s; end
        @(negedge clk);
        acc = cyc;
        aReqAck = 1'b0; aReqSt = 1'b0; bReqAck = 1'b0; bReqSt = 1'b0;
    endtask

    task automatic scramble();
        aCode = 8'($urandom); aArmed = 1'($urandom); aRun = 1'($urandom); aTime = $urandom;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nChecks++;
        if ({aTxd, aBusy, aDone, aOv} !== 4'b1000) begin nFails++;
            $display("FAIL reset_a: txd/busy/done/ovr=%b required 1000", {aTxd, aBusy, aDone, aOv}); end
        nChecks++;
        if ({bTxd, bBusy, bDone, bOv} !== 4'b1000) begin nFails++;
            $display("FAIL reset_b: txd/busy/done/ovr=%b required 1000", {bTxd, bBusy, bDone, bOv}); end
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        nChecks++;
        if ({aTxd, aBusy, aDone, aOv} !== 4'b1000) begin nFails++;
            $display("FAIL idle_a: txd/busy/done/ovr=%b required 1000", {aTxd, aBusy, aDone, aOv}); end
        nChecks++;
        if ({bTxd, bBusy, bDone, bOv} !== 4'b1000) begin nFails++;
            $display("FAIL idle_b: txd/busy/done/ovr=%b required 1000", {bTxd, bBusy, bDone, bOv}); end
    endtask

    task automatic test_ack();
        int acc, nErr, d, db;
        aCode = 8'h10;
        pulse(0, 1'b1, 1'b0, acc);
        scramble();
        expAck(0, 8'h10, acc, DA);
        nChecks++;
        if ({aBusy, aTxd} !== 2'b10) begin nFails++;
            $display("FAIL ack_first_cycle: busy/txd=%b required 10", {aBusy, aTxd}); end
        repeat (30 * DA + 5) @(negedge clk);
        d  = (doneQ[0].size() == 1) ? doneQ[0][0] : -1;
        db = (doneQ[0].size() == 1) ? int'(doneBusyQ[0][0]) : -1;
        drain(0, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL ack_stream: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (d !== acc + 30 * DA || db !== 0) begin nFails++;
            $display("FAIL ack_done: done at %0d busy=%0d, required %0d busy=0", d, db, acc + 30 * DA); end
    endtask

    task automatic test_status();
        int acc, nErr, d;
        aArmed = 1'b1; aRun = 1'b0; aTime = 32'h12345678;
        pulse(0, 1'b0, 1'b1, acc);
        aTime = 32'hDEADBEEF; aArmed = 1'b0; aRun = 1'b1;
        expStatus(0, 1'b1, 1'b0, 32'h12345678, 4, acc, DA);
        repeat (70 * DA + 5) @(negedge clk);
        d = (doneQ[0].size() == 1) ? doneQ[0][0] : -1;
        drain(0, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL status_stream: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (d !== acc + 70 * DA) begin nFails++;
            $display("FAIL status_done: done at %0d, required %0d", d, acc + 70 * DA); end
    endtask

    task automatic test_simultaneous();
        int acc, nErr, lowCnt, d0, d1;
        logic [31:0] t;
        bit ar, ru;
        t = $urandom; ar = 1'($urandom); ru = 1'($urandom);
        aCode = 8'h20; aArmed = ar; aRun = ru; aTime = t;
        pulse(0, 1'b1, 1'b1, acc);
        scramble();
        expAck(0, 8'h20, acc, DA);
        expStatus(0, ar, ru, t, 4, acc + 30 * DA + 1, DA);
        lowCnt = 0;
        while (cyc <= acc + 100 * DA) begin
            if (aBusy !== 1'b1) lowCnt++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        d0 = (doneQ[0].size() == 2) ? doneQ[0][0] : -1;
        d1 = (doneQ[0].size() == 2) ? doneQ[0][1] : -1;
        drain(0, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL simul_stream: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (lowCnt !== 0) begin nFails++; $display("FAIL simul_busy: busy low %0d cycles, required 0", lowCnt); end
        nChecks++;
        if (d0 !== acc + 30 * DA || d1 !== acc + 100 * DA + 1) begin nFails++;
            $display("FAIL simul_done: done at %0d,%0d required %0d,%0d", d0, d1, acc + 30 * DA, acc + 100 * DA + 1); end
    endtask

    task automatic test_overrun();
        int acc, tmp, accOv, nErr, nDone, o, nOv;
        logic [31:0] t;
        bit ar, ru;
        aCode = 8'h33;
        pulse(0, 1'b1, 1'b0, acc);
        repeat (20) @(negedge clk);
        t = $urandom; ar = 1'($urandom); ru = 1'($urandom);
        aArmed = ar; aRun = ru; aTime = t;
        pulse(0, 1'b0, 1'b1, tmp);
        scramble();
        repeat (20) @(negedge clk);
        aCode = 8'h77;
        pulse(0, 1'b1, 1'b0, accOv);
        scramble();
        expAck(0, 8'h33, acc, DA);
        expStatus(0, ar, ru, t, 4, acc + 30 * DA + 1, DA);
        while (cyc < acc + 100 * DA + 10) @(negedge clk);
        nDone = doneQ[0].size();
        nOv   = ovQ[0].size();
        o     = (nOv == 1) ? ovQ[0][0] : -1;
        drain(0, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL ovr_stream: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (nOv !== 1 || o !== accOv) begin nFails++;
            $display("FAIL ovr_pulse: %0d pulses first at %0d, required 1 at %0d", nOv, o, accOv); end
        nChecks++;
        if (nDone !== 2) begin nFails++; $display("FAIL ovr_done: %0d done pulses, required 2", nDone); end
    endtask

    task automatic test_random();
        int acc, tmp, nErr, kind, kind2, n1, nPk, endCyc, d, nDone, lastDone, nOv;
        logic [7:0] c;
        logic [31:0] t;
        bit ar, ru;
        for (int it = 0; it < 6; it++) begin
            kind = $urandom_range(0, 2);
            c = 8'($urandom); ar = 1'($urandom); ru = 1'($urandom); t = $urandom;
            aCode = c; aArmed = ar; aRun = ru; aTime = t;
            pulse(0, kind != 1, kind != 0, acc);
            scramble();
            n1 = (kind == 1) ? 7 : 3;
            if (kind == 1) expStatus(0, ar, ru, t, 4, acc, DA);
            else expAck(0, c, acc, DA);
            endCyc = acc + n1 * 10 * DA;
            nPk = 1;
            if (kind == 2) begin
                expStatus(0, ar, ru, t, 4, endCyc + 1, DA);
                endCyc = endCyc + 1 + 70 * DA;
                nPk = 2;
            end else if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(1, n1 * 10 * DA - 20);
                repeat (d) @(negedge clk);
                c = 8'($urandom); ar = 1'($urandom); ru = 1'($urandom); t = $urandom;
                aCode = c; aArmed = ar; aRun = ru; aTime = t;
                kind2 = $urandom_range(0, 1);
                pulse(0, kind2 == 0, kind2 == 1, tmp);
                scramble();
                if (kind2 == 0) begin expAck(0, c, endCyc + 1, DA); endCyc = endCyc + 1 + 30 * DA; end
                else begin expStatus(0, ar, ru, t, 4, endCyc + 1, DA); endCyc = endCyc + 1 + 70 * DA; end
                nPk = 2;
            end
            while (cyc < endCyc + 5) @(negedge clk);
            nDone    = doneQ[0].size();
            lastDone = (nDone > 0) ? doneQ[0][nDone-1] : -1;
            nOv      = ovQ[0].size();
            drain(0, nErr);
            nChecks++;
            if (nErr !== 0) begin nFails++; $display("FAIL rand%0d_stream: %0d bad bytes, required 0", it, nErr); end
            nChecks++;
            if (nDone !== nPk || lastDone !== endCyc || nOv !== 0) begin nFails++;
                $display("FAIL rand%0d_done: %0d done last %0d ovr %0d, required %0d last %0d ovr 0",
                         it, nDone, lastDone, nOv, nPk, endCyc); end
        end
    endtask

    task automatic test_reset_mid();
        int acc, tmp, nErr, lowCnt, target, d;
        logic [7:0] c;
        aCode = 8'($urandom);
        pulse(0, 1'b1, 1'b0, acc);
        repeat (5) @(negedge clk);
        pulse(0, 1'b0, 1'b1, tmp);
        target = acc + 13 * DA + DA / 2;
        while (cyc < target) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        nChecks++;
        if ({aTxd, aBusy, aDone, aOv} !== 4'b1000) begin nFails++;
            $display("FAIL rstmid_async: txd/busy/done/ovr=%b required 1000", {aTxd, aBusy, aDone, aOv}); end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        drain(0, nErr);
        lowCnt = 0;
        repeat (40 * DA) begin
            @(negedge clk);
            if (aTxd !== 1'b1 || aBusy !== 1'b0) lowCnt++;
        end
        nChecks++;
        if (lowCnt !== 0 || rxQ[0].size() !== 0 || doneQ[0].size() !== 0) begin nFails++;
            $display("FAIL rstmid_quiet: %0d active cycles %0d bytes %0d done, required 0 0 0",
                     lowCnt, rxQ[0].size(), doneQ[0].size()); end
        c = 8'($urandom);
        aCode = c;
        pulse(0, 1'b1, 1'b0, acc);
        scramble();
        expAck(0, c, acc, DA);
        repeat (30 * DA + 5) @(negedge clk);
        d = (doneQ[0].size() == 1) ? doneQ[0][0] : -1;
        drain(0, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL rstmid_after: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (d !== acc + 30 * DA) begin nFails++;
            $display("FAIL rstmid_done: done at %0d, required %0d", d, acc + 30 * DA); end
    endtask

    task automatic test_param();
        int acc, nErr, d;
        logic [15:0] t;
        bit ar, ru;
        bArmed = 1'b0; bRun = 1'b0; bTime = 16'hABCD;
        pulse(1, 1'b0, 1'b1, acc);
        bTime = 16'h1357;
        expStatus(1, 1'b0, 1'b0, 32'h0000ABCD, 2, acc, DB);
        repeat (50 * DB + 5) @(negedge clk);
        d = (doneQ[1].size() == 1) ? doneQ[1][0] : -1;
        drain(1, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL param_stream: %0d bad bytes, required 0", nErr); end
        nChecks++;
        if (d !== acc + 50 * DB) begin nFails++;
            $display("FAIL param_done: done at %0d, required %0d", d, acc + 50 * DB); end
        t = 16'($urandom); ar = 1'($urandom); ru = 1'($urandom);
        bTime = t; bArmed = ar; bRun = ru;
        pulse(1, 1'b0, 1'b1, acc);
        bTime = ~t;
        expStatus(1, ar, ru, {16'h0, t}, 2, acc, DB);
        repeat (50 * DB + 5) @(negedge clk);
        drain(1, nErr);
        nChecks++;
        if (nErr !== 0) begin nFails++; $display("FAIL param_rand_stream: %0d bad bytes, required 0", nErr); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_status();
        test_simultaneous();
        test_overrun();
        test_random();
        test_reset_mid();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
